// File: rtl/crush_pkg.sv
// Shared definitions for the crush scheduler: FSM states, level constants
// and the level-to-mask helper used by the shared mask unit.
package crush_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEVEL  = 3'd1,
        CH1    = 3'd2,
        CH2    = 3'd3,
        CH3    = 3'd4,
        COMMIT = 3'd5
    } crush_state_e;

    // Number of distinct crush levels (0..10)
    localparam int LEVELS     = 11;
    // Spacing between level thresholds: T(k) = STEP * k
    localparam int STEP       = 2000;
    // Widest sample the mask helper can describe
    localparam int MASK_MAX_W = 64;

    // Keep the top lvl+2 bits of a w-bit sample; the top level keeps everything.
    function automatic logic [MASK_MAX_W-1:0] lvl_mask(input logic [3:0] lvl, input int w);
        logic [MASK_MAX_W-1:0] m;
        int keep;
        m    = {MASK_MAX_W{1'b0}};
        keep = int'(lvl) + 2;
        for (int i = 0; i < MASK_MAX_W; i++) begin
            if ((int'(lvl) >= (LEVELS - 1)) || (i >= (w - keep))) begin
                m[i] = 1'b1;
            end else begin
                m[i] = 1'b0;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/crush_sched_if.sv
// Sample-side bus of the crush scheduler: strobe, four inputs, four
// outputs and status. The slave modport is the scheduler's view.
interface crush_sched_if #(
    parameter int W = 16
);
    logic         sample_clk;
    logic [W-1:0] sample_in0;
    logic [W-1:0] sample_in1;
    logic [W-1:0] sample_in2;
    logic [W-1:0] sample_in3;
    logic [W-1:0] sample_out0;
    logic [W-1:0] sample_out1;
    logic [W-1:0] sample_out2;
    logic [W-1:0] sample_out3;
    logic [3:0]   level;
    logic         busy;
    logic [7:0]   overrun_cnt;

    modport master (
        output sample_clk, sample_in0, sample_in1, sample_in2, sample_in3,
        input  sample_out0, sample_out1, sample_out2, sample_out3,
        input  level, busy, overrun_cnt
    );

    modport slave (
        input  sample_clk, sample_in0, sample_in1, sample_in2, sample_in3,
        output sample_out0, sample_out1, sample_out2, sample_out3,
        output level, busy, overrun_cnt
    );
endinterface

// File: rtl/crush_mask_unit.sv
// Shared bit-crusher: clears the low bits of a sample according to the
// crush level. Purely combinational; time-multiplexed over the channels.
module crush_mask_unit
    import crush_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [3:0]   level,
    input  logic [W-1:0] sample,
    output logic [W-1:0] crushed
);

    logic [MASK_MAX_W-1:0] mask_s;

    // Build the level mask and apply it to the sample
    always_comb begin
        mask_s  = lvl_mask(level, W);
        crushed = sample & mask_s[W-1:0];
    end

endmodule

// File: rtl/crush_sched.sv
// Crush scheduler top: detects sample_clk rising edges, captures a frame,
// derives a crush level from channel 0, crushes channels 1..3 through one
// shared mask unit and commits all outputs together six edges later.
// Optional build macro: CRUSH_HYST_EN adds hysteresis to level changes.
module crush_sched
    import crush_pkg::*;
#(
    parameter int W    = 16,
    parameter int HYST = 256
) (
    input  logic          clk,
    input  logic          rst_n,
    crush_sched_if.slave  bus
);

    crush_state_e state_r;
    logic         prev_clk_r;
    logic [W-1:0] frame0_r, frame1_r, frame2_r, frame3_r;
    logic [W-1:0] hold1_r, hold2_r, hold3_r;
    logic [W-1:0] out0_r, out1_r, out2_r, out3_r;
    logic [3:0]   level_r;
    logic [3:0]   level_new_r;
    logic         busy_r;
    logic [7:0]   ovr_r;

    logic         rise_s;
    logic [3:0]   level_calc_s;
    logic [W-1:0] mask_in_s;
    logic [W-1:0] mask_out_s;

    // Number of thresholds T(k)+offset that the signed sample strictly exceeds
    function automatic logic [3:0] count_above(input logic [W-1:0] s, input int offset);
        int sval;
        int cnt;
        sval = int'($signed(s));
        cnt  = 0;
        for (int k = 1; k < LEVELS; k++) begin
            if (sval > ((k * STEP) + offset)) begin
                cnt = cnt + 1;
            end else begin
                cnt = cnt;
            end
        end
        return cnt[3:0];
    endfunction

    assign rise_s = bus.sample_clk & ~prev_clk_r;

`ifdef CRUSH_HYST_EN
    logic [3:0] up_s;
    logic [3:0] dn_s;

    // Level with hysteresis: move up only past T+HYST, down only below T-HYST
    always_comb begin
        up_s = count_above(frame0_r, HYST);
        dn_s = count_above(frame0_r, -HYST);
        if (up_s > level_r) begin
            level_calc_s = up_s;
        end else if (dn_s < level_r) begin
            level_calc_s = dn_s;
        end else begin
            level_calc_s = level_r;
        end
    end
`else
    // Plain level: number of thresholds exceeded by the control sample
    always_comb begin
        level_calc_s = count_above(frame0_r, 0);
    end
`endif

    // Route the channel owned by the current state into the shared masker
    always_comb begin
        mask_in_s = {W{1'b0}};
        case (state_r)
            CH1:     mask_in_s = frame1_r;
            CH2:     mask_in_s = frame2_r;
            CH3:     mask_in_s = frame3_r;
            default: mask_in_s = {W{1'b0}};
        endcase
    end

    crush_mask_unit #(.W(W)) u_mask (
        .level   (level_new_r),
        .sample  (mask_in_s),
        .crushed (mask_out_s)
    );

    // Frame sequencer, overrun counter and all registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            prev_clk_r  <= 1'b1;
            frame0_r    <= {W{1'b0}};
            frame1_r    <= {W{1'b0}};
            frame2_r    <= {W{1'b0}};
            frame3_r    <= {W{1'b0}};
            hold1_r     <= {W{1'b0}};
            hold2_r     <= {W{1'b0}};
            hold3_r     <= {W{1'b0}};
            out0_r      <= {W{1'b0}};
            out1_r      <= {W{1'b0}};
            out2_r      <= {W{1'b0}};
            out3_r      <= {W{1'b0}};
            level_r     <= 4'd0;
            level_new_r <= 4'd0;
            busy_r      <= 1'b0;
            ovr_r       <= 8'd0;
        end else begin
            prev_clk_r <= bus.sample_clk;
            // Edges arriving while a frame is in flight (COMMIT included) are dropped
            if (rise_s && (state_r != IDLE) && (ovr_r != 8'd255)) begin
                ovr_r <= ovr_r + 8'd1;
            end
            case (state_r)
                IDLE: begin
                    if (rise_s) begin
                        frame0_r <= bus.sample_in0;
                        frame1_r <= bus.sample_in1;
                        frame2_r <= bus.sample_in2;
                        frame3_r <= bus.sample_in3;
                        busy_r   <= 1'b1;
                        state_r  <= LEVEL;
                    end
                end
                LEVEL: begin
                    level_new_r <= level_calc_s;
                    state_r     <= CH1;
                end
                CH1: begin
                    hold1_r <= mask_out_s;
                    state_r <= CH2;
                end
                CH2: begin
                    hold2_r <= mask_out_s;
                    state_r <= CH3;
                end
                CH3: begin
                    hold3_r <= mask_out_s;
                    state_r <= COMMIT;
                end
                COMMIT: begin
                    out0_r  <= frame0_r;
                    out1_r  <= hold1_r;
                    out2_r  <= hold2_r;
                    out3_r  <= hold3_r;
                    level_r <= level_new_r;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.sample_out0 = out0_r;
    assign bus.sample_out1 = out1_r;
    assign bus.sample_out2 = out2_r;
    assign bus.sample_out3 = out3_r;
    assign bus.level       = level_r;
    assign bus.busy        = busy_r;
    assign bus.overrun_cnt = ovr_r;

endmodule
